// File: rtl/dmi_arbiter_pkg.sv
// Shared DMI transaction types, response codes and arbiter state encoding for the
// Debug Module side of the DMI, plus a small index-width helper.
package dmi_arbiter_pkg;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  localparam logic [1:0] DmiRespSuccess = 2'h0;
  localparam logic [1:0] DmiRespFailed  = 2'h2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RESP,
    DELIVER
  } dmi_arb_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dmi_rr_pick.sv
// Combinational round-robin picker: first eligible requester after 'last', wrapping.
// Also used for sharing the system-bus access port.
module dmi_rr_pick
  import dmi_arbiter_pkg::*;
#(
  parameter int NumReq = 2,
  localparam int IdxW  = idx_width(NumReq)
) (
  input  logic [NumReq-1:0] eligible,
  input  logic [IdxW-1:0]   last,
  output logic [IdxW-1:0]   win,
  output logic              any
);

  int idx;

  // Search last+1 .. last so the previous winner has lowest priority.
  always_comb begin
    win = last;
    any = 1'b0;
    idx = 0;
    for (int i = 1; i <= NumReq; i++) begin
      idx = (int'(last) + i) % NumReq;
      if (!any && eligible[idx]) begin
        any = 1'b1;
        win = IdxW'(idx);
      end
    end
  end

endmodule

// File: rtl/dmi_arbiter.sv
// Shares the single DM-side DMI port between several requesters with round-robin grant,
// one outstanding transaction, per-requester abort and an optional response timeout.
module dmi_arbiter
  import dmi_arbiter_pkg::*;
#(
  parameter int NumReq        = 2,
  parameter int TimeoutCycles = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NumReq-1:0]   req_valid_i,
  input  dmi_req_t            req_i [NumReq],
  output logic [NumReq-1:0]   req_ready_o,
  input  logic [NumReq-1:0]   clear_i,
  output dmi_resp_t           resp_o,
  output logic [NumReq-1:0]   resp_valid_o,
  input  logic [NumReq-1:0]   resp_ready_i,
  output dmi_req_t            dmi_req_o,
  output logic                dmi_req_valid_o,
  input  logic                dmi_req_ready_i,
  input  dmi_resp_t           dmi_resp_i,
  input  logic                dmi_resp_valid_i,
  output logic                dmi_resp_ready_o,
  output logic [NumReq-1:0]   gnt_o,
  output logic                busy_o
);

  localparam int IdxW = idx_width(NumReq);
  localparam int TmrW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [TmrW-1:0]   TmrLast = TmrW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
  localparam logic [TmrW-1:0]   TmrMax  = '1;
  localparam logic [NumReq-1:0] OneHot0 = NumReq'(1);

  dmi_arb_state_e   state_q, state_d;
  logic             drain_q, drain_d;
  logic             abort_q, abort_d;
  logic [IdxW-1:0]  last_q, last_d;
  logic [IdxW-1:0]  gnt_q, gnt_d;
  logic [TmrW-1:0]  timer_q, timer_d;
  dmi_req_t         req_q, req_d;
  dmi_resp_t        resp_q, resp_d;

  logic [NumReq-1:0] eligible;
  logic [IdxW-1:0]   win;
  logic              any;
  logic [NumReq-1:0] gnt_oh;
  logic              clr_own;
  logic              rdy_own;

  assign eligible = req_valid_i & ~clear_i;
  assign gnt_oh   = OneHot0 << gnt_q;
  assign clr_own  = clear_i[gnt_q];
  assign rdy_own  = resp_ready_i[gnt_q];

  dmi_rr_pick #(.NumReq(NumReq)) u_pick (
    .eligible (eligible),
    .last     (last_q),
    .win      (win),
    .any      (any)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      drain_q <= 1'b0;
      abort_q <= 1'b0;
      last_q  <= IdxW'(NumReq - 1);
      gnt_q   <= '0;
      timer_q <= '0;
      req_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      abort_q <= abort_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      timer_q <= timer_d;
      req_q   <= req_d;
      resp_q  <= resp_d;
    end
  end

  // Drain swallows the one late DM response left over by an abort or timeout;
  // grants stay blocked until it arrives so it can never reach a new owner.
  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    abort_d     = abort_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    timer_d     = timer_q;
    req_d       = req_q;
    resp_d      = resp_q;
    req_ready_o = '0;

    if (drain_q && dmi_resp_valid_i) drain_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (!drain_q && any && !rst_i) begin
          req_ready_o = OneHot0 << win;
          req_d       = req_i[win];
          gnt_d       = win;
          last_d      = win;
          abort_d     = 1'b0;
          state_d     = REQ;
        end
      end
      REQ: begin
        if (clr_own) abort_d = 1'b1;
        if (dmi_req_ready_i) begin
          timer_d = '0;
          if (abort_q || clr_own) begin
            drain_d = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT_RESP;
          end
        end
      end
      WAIT_RESP: begin
        if (timer_q != TmrMax) timer_d = timer_q + 1'b1;
        if (dmi_resp_valid_i) begin
          resp_d  = dmi_resp_i;
          state_d = DELIVER;
        end else if (TimeoutCycles != 0 && timer_q == TmrLast) begin
          resp_d  = '{data: 32'h0, resp: DmiRespFailed};
          drain_d = 1'b1;
          state_d = DELIVER;
        end else if (clr_own) begin
          drain_d = 1'b1;
          state_d = IDLE;
        end
      end
      DELIVER: begin
        if (clr_own || rdy_own) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt_o            = (state_q != IDLE) ? gnt_oh : '0;
  assign resp_valid_o     = (state_q == DELIVER) ? gnt_oh : '0;
  assign resp_o           = resp_q;
  assign dmi_req_o        = req_q;
  assign dmi_req_valid_o  = (state_q == REQ);
  assign dmi_resp_ready_o = (state_q == WAIT_RESP) || drain_q;
  assign busy_o           = (state_q != IDLE) || drain_q;

endmodule

// File: tb/tb_dmi_arbiter.sv
// Directed self-checking bench for dmi_arbiter: grant order, timeout, abort/drain,
// timeout/response race and reset mid-delivery.
module tb_dmi_arbiter;
  import dmi_arbiter_pkg::*;

  localparam int NumReq        = 2;
  localparam int TimeoutCycles = 8;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NumReq-1:0] req_valid_i;
  dmi_req_t          req_i [NumReq];
  logic [NumReq-1:0] req_ready_o;
  logic [NumReq-1:0] clear_i;
  dmi_resp_t         resp_o;
  logic [NumReq-1:0] resp_valid_o;
  logic [NumReq-1:0] resp_ready_i;
  dmi_req_t          dmi_req_o;
  logic              dmi_req_valid_o;
  logic              dmi_req_ready_i;
  dmi_resp_t         dmi_resp_i;
  logic              dmi_resp_valid_i;
  logic              dmi_resp_ready_o;
  logic [NumReq-1:0] gnt_o;
  logic              busy_o;

  int compared   = 0;
  int mismatched = 0;
  int w;
  logic [1:0] exp_oh;

  always #5 clk_i = ~clk_i;

  dmi_arbiter #(.NumReq(NumReq), .TimeoutCycles(TimeoutCycles)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .req_valid_i      (req_valid_i),
    .req_i            (req_i),
    .req_ready_o      (req_ready_o),
    .clear_i          (clear_i),
    .resp_o           (resp_o),
    .resp_valid_o     (resp_valid_o),
    .resp_ready_i     (resp_ready_i),
    .dmi_req_o        (dmi_req_o),
    .dmi_req_valid_o  (dmi_req_valid_o),
    .dmi_req_ready_i  (dmi_req_ready_i),
    .dmi_resp_i       (dmi_resp_i),
    .dmi_resp_valid_i (dmi_resp_valid_i),
    .dmi_resp_ready_o (dmi_resp_ready_o),
    .gnt_o            (gnt_o),
    .busy_o           (busy_o)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int k, input logic [6:0] addr, input dtm_op_e op, input logic [31:0] data);
    req_i[k].addr  = addr;
    req_i[k].op    = op;
    req_i[k].data  = data;
    req_valid_i[k] = 1'b1;
    #1;
  endtask

  task automatic dmAccept();
    dmi_req_ready_i = 1'b1;
    tick();
    dmi_req_ready_i = 1'b0;
    #1;
  endtask

  task automatic dmRespond(input logic [31:0] data);
    dmi_resp_i       = '{data: data, resp: DmiRespSuccess};
    dmi_resp_valid_i = 1'b1;
    tick();
    dmi_resp_valid_i = 1'b0;
    #1;
  endtask

  task automatic resetPulse();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i            = 1'b1;
    req_valid_i      = '0;
    req_i[0]         = '0;
    req_i[1]         = '0;
    clear_i          = '0;
    resp_ready_i     = '0;
    dmi_req_ready_i  = 1'b0;
    dmi_resp_i       = '0;
    dmi_resp_valid_i = 1'b0;
    tick(2);

    checkOutput("rst_gnt", 64'(gnt_o), 64'h0);
    checkOutput("rst_busy", 64'(busy_o), 64'h0);
    checkOutput("rst_resp", 64'(resp_o), 64'h0);
    checkOutput("rst_dmi_req_valid", 64'(dmi_req_valid_o), 64'h0);
    checkOutput("rst_dmi_resp_ready", 64'(dmi_resp_ready_o), 64'h0);
    checkOutput("rst_resp_valid", 64'(resp_valid_o), 64'h0);
    rst_i = 1'b0;
    #1;

    // Single read from requester 0
    applyStimulus(0, 7'h11, DTM_READ, 32'h0);
    checkOutput("t1_req_ready", 64'(req_ready_o), 64'h1);
    checkOutput("t1_no_early_valid", 64'(dmi_req_valid_o), 64'h0);
    tick();
    req_valid_i = '0;
    #1;
    checkOutput("t1_dmi_req_valid", 64'(dmi_req_valid_o), 64'h1);
    checkOutput("t1_addr", 64'(dmi_req_o.addr), 64'h11);
    checkOutput("t1_op", 64'(dmi_req_o.op), 64'h1);
    checkOutput("t1_gnt", 64'(gnt_o), 64'h1);
    dmAccept();
    checkOutput("t1_dmi_resp_ready", 64'(dmi_resp_ready_o), 64'h1);
    checkOutput("t1_req_dropped", 64'(dmi_req_valid_o), 64'h0);
    dmRespond(32'hCAFE0001);
    checkOutput("t1_resp_valid", 64'(resp_valid_o), 64'h1);
    checkOutput("t1_resp_data", 64'(resp_o.data), 64'hCAFE0001);
    checkOutput("t1_resp_code", 64'(resp_o.resp), 64'h0);
    tick();
    checkOutput("t1_resp_held", 64'(resp_valid_o), 64'h1);
    resp_ready_i = 2'b01;
    tick();
    resp_ready_i = '0;
    #1;
    checkOutput("t1_done_valid", 64'(resp_valid_o), 64'h0);
    checkOutput("t1_done_busy", 64'(busy_o), 64'h0);

    // Round-robin between two always-valid requesters
    resetPulse();
    for (int t = 0; t < 4; t++) begin
      w      = t % 2;
      exp_oh = (w == 0) ? 2'b01 : 2'b10;
      req_i[0].data = 32'hA000_0000 + 32'(t);
      req_i[1].data = 32'hB000_0000 + 32'(t);
      req_valid_i   = 2'b11;
      #1;
      checkOutput($sformatf("t2_ready_%0d", t), 64'(req_ready_o), 64'(exp_oh));
      tick();
      checkOutput($sformatf("t2_gnt_%0d", t), 64'(gnt_o), 64'(exp_oh));
      checkOutput($sformatf("t2_data_%0d", t), 64'(dmi_req_o.data),
                  64'(((w == 0) ? 32'hA000_0000 : 32'hB000_0000) + 32'(t)));
      checkOutput($sformatf("t2_no_ready_%0d", t), 64'(req_ready_o), 64'h0);
      dmAccept();
      dmRespond(32'hD000_0000 + 32'(t));
      checkOutput($sformatf("t2_resp_valid_%0d", t), 64'(resp_valid_o), 64'(exp_oh));
      checkOutput($sformatf("t2_resp_data_%0d", t), 64'(resp_o.data), 64'(32'hD000_0000 + 32'(t)));
      resp_ready_i = 2'b11;
      tick();
      resp_ready_i = '0;
    end
    req_valid_i = '0;
    #1;

    // Timeout with requester 1 queued behind the late response
    applyStimulus(0, 7'h20, DTM_READ, 32'h0);
    checkOutput("t3_ready", 64'(req_ready_o), 64'h1);
    tick();
    req_valid_i = 2'b10;
    #1;
    checkOutput("t3_no_ready_in_req", 64'(req_ready_o), 64'h0);
    dmAccept();
    for (int i = 1; i <= 7; i++) begin
      tick();
      checkOutput($sformatf("t3_waiting_%0d", i), 64'(resp_valid_o), 64'h0);
    end
    tick();
    checkOutput("t3_to_valid", 64'(resp_valid_o), 64'h1);
    checkOutput("t3_to_code", 64'(resp_o.resp), 64'h2);
    checkOutput("t3_to_data", 64'(resp_o.data), 64'h0);
    checkOutput("t3_to_busy", 64'(busy_o), 64'h1);
    resp_ready_i = 2'b01;
    tick();
    resp_ready_i = '0;
    #1;
    checkOutput("t3_drain_busy", 64'(busy_o), 64'h1);
    checkOutput("t3_drain_no_grant", 64'(req_ready_o), 64'h0);
    checkOutput("t3_drain_resp_ready", 64'(dmi_resp_ready_o), 64'h1);
    tick(2);
    checkOutput("t3_drain_still_blocked", 64'(req_ready_o), 64'h0);
    dmRespond(32'hDEADBEEF);
    checkOutput("t3_swallowed", 64'(resp_valid_o), 64'h0);
    checkOutput("t3_idle_busy", 64'(busy_o), 64'h0);
    checkOutput("t3_req1_ready", 64'(req_ready_o), 64'h2);
    tick();
    req_valid_i = '0;
    #1;
    checkOutput("t3_req1_gnt", 64'(gnt_o), 64'h2);
    dmAccept();
    dmRespond(32'h1111_0003);
    checkOutput("t3_req1_resp_valid", 64'(resp_valid_o), 64'h2);
    checkOutput("t3_req1_resp_data", 64'(resp_o.data), 64'h1111_0003);
    resp_ready_i = 2'b10;
    tick();
    resp_ready_i = '0;
    #1;

    // Abort in WAIT_RESP, response swallowed, queued requester 1 follows
    applyStimulus(0, 7'h30, DTM_WRITE, 32'h0000_0A0A);
    req_i[1].data = 32'h0000_1B1B;
    tick();
    req_valid_i = 2'b10;
    #1;
    checkOutput("t4_gnt0", 64'(gnt_o), 64'h1);
    dmAccept();
    clear_i = 2'b01;
    tick();
    clear_i = '0;
    #1;
    checkOutput("t4_no_resp", 64'(resp_valid_o), 64'h0);
    checkOutput("t4_drain_busy", 64'(busy_o), 64'h1);
    checkOutput("t4_drain_no_grant", 64'(req_ready_o), 64'h0);
    tick();
    checkOutput("t4_no_resp_later", 64'(resp_valid_o), 64'h0);
    dmRespond(32'hBAD0BAD0);
    checkOutput("t4_swallowed", 64'(resp_valid_o), 64'h0);
    checkOutput("t4_req1_ready", 64'(req_ready_o), 64'h2);
    tick();
    req_valid_i = '0;
    #1;
    checkOutput("t4_req1_gnt", 64'(gnt_o), 64'h2);
    checkOutput("t4_req1_data", 64'(dmi_req_o.data), 64'h0000_1B1B);
    dmAccept();
    dmRespond(32'h2222_0004);
    checkOutput("t4_req1_resp_valid", 64'(resp_valid_o), 64'h2);
    checkOutput("t4_req1_resp_data", 64'(resp_o.data), 64'h2222_0004);
    resp_ready_i = 2'b10;
    tick();
    resp_ready_i = '0;
    #1;

    // Real response arrives in the timeout cycle
    applyStimulus(0, 7'h40, DTM_READ, 32'h0);
    tick();
    req_valid_i = '0;
    #1;
    dmAccept();
    tick(7);
    checkOutput("t5_still_waiting", 64'(resp_valid_o), 64'h0);
    dmRespond(32'h5555AAAA);
    checkOutput("t5_resp_valid", 64'(resp_valid_o), 64'h1);
    checkOutput("t5_resp_data", 64'(resp_o.data), 64'h5555AAAA);
    checkOutput("t5_resp_code", 64'(resp_o.resp), 64'h0);
    resp_ready_i = 2'b01;
    tick();
    resp_ready_i = '0;
    #1;
    checkOutput("t5_no_drain_busy", 64'(busy_o), 64'h0);
    checkOutput("t5_no_drain_ready", 64'(dmi_resp_ready_o), 64'h0);

    // Reset while a response is waiting in DELIVER
    applyStimulus(0, 7'h50, DTM_READ, 32'h0);
    tick();
    req_valid_i = '0;
    #1;
    dmAccept();
    dmRespond(32'h6666_0006);
    checkOutput("t6_deliver", 64'(resp_valid_o), 64'h1);
    resetPulse();
    checkOutput("t6_resp_valid", 64'(resp_valid_o), 64'h0);
    checkOutput("t6_gnt", 64'(gnt_o), 64'h0);
    checkOutput("t6_busy", 64'(busy_o), 64'h0);
    checkOutput("t6_resp", 64'(resp_o), 64'h0);
    checkOutput("t6_dmi_req", 64'(dmi_req_o), 64'h0);
    checkOutput("t6_dmi_req_valid", 64'(dmi_req_valid_o), 64'h0);
    checkOutput("t6_dmi_resp_ready", 64'(dmi_resp_ready_o), 64'h0);
    checkOutput("t6_req_ready", 64'(req_ready_o), 64'h0);
    req_valid_i = 2'b11;
    #1;
    checkOutput("t6_next_ready", 64'(req_ready_o), 64'h1);
    tick();
    checkOutput("t6_next_gnt", 64'(gnt_o), 64'h1);
    req_valid_i = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
